branch_predict_unit: RTL

- Parametrised successor to the pipeline's branch-condition logic.
- Resolves the full RV32I branch set in execute and drives mispredict/flush.
- Holds a bimodal table of 2-bit saturating counters that gives fetch a taken/not-taken direction prediction.
- Direction only. Target computation stays in the existing PC/ALU path.

---
 rtl/bru_pkg.sv | 39 +++
 rtl/branch_resolve.sv | 57 +++++
 rtl/branch_predict_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
// Package for the branch predict unit.
//
// Holds the branch-op encodings, the counter width, the conditional-branch
// classifier and the 2-bit saturating counter update.
package bru_pkg;

    // Width of each bimodal counter.
    localparam int CNT_W = 2;

    // Branch operation encodings. Codes 9-15 are not listed and resolve as
    // "no branch".
    typedef enum logic [3:0] {
        BR_NB   = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_op_e;

    // True for the conditional compares (BEQ..BGEU). Only these train the
    // predictor.
    function automatic logic is_cond_br(input logic [3:0] op);
        return (op >= BR_BEQ) && (op <= BR_BGEU);
    endfunction

    // Move a counter one step towards taken or not-taken, holding at the ends.
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                    input logic             taken);
        if (taken) begin
            return (cnt == '1) ? cnt : cnt + 1'b1;
        end
        return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution for the execute stage.
//
// Ports:
//   ex_valid    in   execute stage holds a valid instruction
//   br_op       in   branch op (bru_pkg::br_op_e encodings)
//   opr1, opr2  in   rs1 / rs2 values
//   pred_taken  in   direction predicted at fetch
//   br_taken    out  resolved direction
//   mispredict  out  resolved direction disagrees with the prediction
module branch_resolve
    import bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            ex_valid,
    input  logic [3:0]      br_op,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    input  logic            pred_taken,
    output logic            br_taken,
    output logic            mispredict
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (opr1 == opr2);
    assign lt_s = ($signed(opr1) < $signed(opr2));
    assign lt_u = (opr1 < opr2);

    // Jumps are always taken, so a jump mispredicts exactly when fetch guessed
    // not-taken. Unlisted op codes fall into the default and resolve as no
    // branch.
    always_comb begin
        br_taken   = 1'b0;
        mispredict = 1'b0;
        if (ex_valid) begin
            case (br_op)
                BR_BEQ:          br_taken = eq;
                BR_BNE:          br_taken = ~eq;
                BR_BLT:          br_taken = lt_s;
                BR_BGE:          br_taken = ~lt_s;
                BR_BLTU:         br_taken = lt_u;
                BR_BGEU:         br_taken = ~lt_u;
                BR_JAL, BR_JALR: br_taken = 1'b1;
                default:         br_taken = 1'b0;
            endcase
            if (is_cond_br(br_op)) begin
                mispredict = br_taken ^ pred_taken;
            end else if ((br_op == BR_JAL) || (br_op == BR_JALR)) begin
                mispredict = ~pred_taken;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: bimodal direction predictor plus RV32I branch resolve.
//
// Fetch reads a 2-bit counter indexed by if_pc[IDX_W+1:2] with zero latency.
// Execute resolves the branch, flags a mispredict and trains the same table.
// The table has no tags, so PCs that share an index share a counter.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   if_pc            fetch PC
//   if_pred_taken    predicted direction for if_pc
//   ex_valid         execute stage holds a valid instruction
//   ex_pc            execute-stage PC (selects the counter to train)
//   ex_br_op         branch op (bru_pkg::br_op_e)
//   ex_opr1/2        rs1 / rs2 values
//   ex_pred_taken    prediction piped down from fetch
//   ex_br_taken      resolved direction
//   ex_mispredict    flush/redirect request
//   perf_branches    conditional branches trained     (BRU_PERF_CNT_EN only)
//   perf_mispredicts mispredict cycles, all ops       (BRU_PERF_CNT_EN only)
//   perf_taken       conditional branches taken       (BRU_PERF_CNT_EN only)
//
// Define BRU_PERF_CNT_EN to add the three performance counters.
module branch_predict_unit
    import bru_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               IDX_W    = 6,
    parameter logic [CNT_W-1:0] CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [3:0]      ex_br_op,
    input  logic [XLEN-1:0] ex_opr1,
    input  logic [XLEN-1:0] ex_opr2,
    input  logic            ex_pred_taken,
    output logic            ex_br_taken,
    output logic            ex_mispredict
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts,
    output logic [31:0]     perf_taken
`endif
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [CNT_W-1:0] cnt_table [DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             res_taken;
    logic             res_mispredict;
    logic             do_update;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // PC bits outside the index never reach the predictor.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    branch_resolve #(
        .XLEN(XLEN)
    ) u_resolve (
        .ex_valid   (ex_valid),
        .br_op      (ex_br_op),
        .opr1       (ex_opr1),
        .opr2       (ex_opr2),
        .pred_taken (ex_pred_taken),
        .br_taken   (res_taken),
        .mispredict (res_mispredict)
    );

    // Only valid conditional branches train the table; jumps are always taken
    // and would just push every aliased counter towards taken.
    assign do_update = ex_valid && is_cond_br(ex_br_op);

    // Reset has priority over training, so an update in the reset cycle is
    // dropped. Lookup reads the array directly, so a same-cycle update to the
    // looked-up entry only becomes visible on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_table[i] <= CNT_INIT;
            end
        end else if (do_update) begin
            cnt_table[ex_idx] <= sat_update(cnt_table[ex_idx], res_taken);
        end
    end

    assign if_pred_taken = rst ? 1'b0 : cnt_table[if_idx][CNT_W-1];
    assign ex_br_taken   = rst ? 1'b0 : res_taken;
    assign ex_mispredict = rst ? 1'b0 : res_mispredict;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;
    logic [31:0] taken_q;

    // Counters advance on the same edge as the table update and wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
            taken_q       <= '0;
        end else begin
            if (do_update) begin
                branches_q <= branches_q + 32'd1;
            end
            if (res_mispredict) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
            if (do_update && res_taken) begin
                taken_q <= taken_q + 32'd1;
            end
        end
    end

    assign perf_branches    = rst ? 32'd0 : branches_q;
    assign perf_mispredicts = rst ? 32'd0 : mispredicts_q;
    assign perf_taken       = rst ? 32'd0 : taken_q;
`endif

endmodule
